// File: rtl/apb3_seq_pkg.sv
// Shared types for the APB3 command sequencer.
// Covers the opcodes, FSM states, transfer phase and the response record.
package apb3_seq_pkg;

    localparam int SEQ_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_VERIFY = 2'd2,
        OP_RMW    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic {
        PH_READ  = 1'b0,
        PH_WRITE = 1'b1
    } phase_e;

    typedef struct packed {
        logic [SEQ_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  mismatch;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb3_seq_wdog.sv
// PREADY wait counter. It is cleared at each SETUP and counts ACCESS cycles that have PREADY low.
module apb3_seq_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High during the last ACCESS cycle that may still wait; a further low PREADY abandons the transfer.
    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb3_cmd_sequencer.sv
// APB3 master that runs WRITE / READ / VERIFY / RMW register commands.
// Each command produces exactly one response, and only one command is in flight at a time.
module apb3_cmd_sequencer
    import apb3_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = SEQ_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_mismatch,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_e            r_state;
    phase_e            r_phase;
    op_e               r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mask;
    rsp_t              r_rsp;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    op_e               w_cmd_op;
    logic              w_wd_clr;
    logic              w_wd_inc;
    logic              w_wd_expired;
    logic [DATA_W-1:0] w_rmw_wval;
    logic              w_mismatch;

    assign w_cmd_op   = op_e'(cmd_op);
    assign w_wd_clr   = (r_state == ST_SETUP);
    assign w_wd_inc   = (r_state == ST_ACCESS) && !pready;
    assign w_rmw_wval = (prdata & ~r_mask) | (r_data & r_mask);
    assign w_mismatch = |((prdata ^ r_data) & r_mask);

    apb3_seq_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_wd_clr),
        .i_inc    (w_wd_inc),
        .o_expired(w_wd_expired)
    );

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge r_* values
    // no matter how the statements are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= PH_READ;
            r_op        <= OP_WRITE;
            r_data      <= '0;
            r_mask      <= '0;
            r_rsp       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= w_cmd_op;
                        r_data      <= cmd_data;
                        r_mask      <= cmd_mask;
                        r_phase     <= (w_cmd_op == OP_WRITE) ? PH_WRITE : PH_READ;
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= (w_cmd_op == OP_WRITE);
                        r_pwdata    <= (w_cmd_op == OP_WRITE) ? cmd_data : '0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_rsp       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rsp.slverr <= r_rsp.slverr | pslverr;
                        if (r_phase == PH_READ) begin
                            r_rsp.rdata <= SEQ_DATA_W'(prdata);
                            if (r_op == OP_VERIFY) r_rsp.mismatch <= w_mismatch;
                        end
                        // RMW turns straight into its write phase; psel stays high through the new SETUP.
                        if (r_phase == PH_READ && r_op == OP_RMW && !pslverr) begin
                            r_phase   <= PH_WRITE;
                            r_pwrite  <= 1'b1;
                            r_pwdata  <= w_rmw_wval;
                            r_penable <= 1'b0;
                            r_state   <= ST_SETUP;
                        end else begin
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_pwrite    <= 1'b0;
                            r_pwdata    <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else if (w_wd_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_pwrite      <= 1'b0;
                        r_pwdata      <= '0;
                        r_rsp.timeout <= 1'b1;
                        r_rsp.rdata   <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp       <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = DATA_W'(r_rsp.rdata);
    assign rsp_slverr   = r_rsp.slverr;
    assign rsp_mismatch = r_rsp.mismatch;
    assign rsp_timeout  = r_rsp.timeout;
    assign paddr        = r_paddr;
    assign psel         = r_psel;
    assign penable      = r_penable;
    assign pwrite       = r_pwrite;
    assign pwdata       = r_pwdata;

endmodule

// File: tb/tb_apb3_cmd_sequencer.sv
// Bench for apb3_cmd_sequencer: a table of commands checked through a response scoreboard,
// plus hand-written sequences for cycle timing, backpressure and mid-transfer reset.
module tb_apb3_cmd_sequencer;
    import apb3_seq_pkg::*;

    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_mismatch;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb3_cmd_sequencer #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_mismatch(rsp_mismatch),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    // Behavioural APB slave: 16-word register file with programmable wait, stuck-low and error.
    logic [31:0] mem [16] = '{default: 32'h0};
    int          wait_cycles = 0;
    bit          stuck = 1'b0;
    bit          err_en = 1'b0;
    int          wcnt = 0;

    assign pready  = psel && penable && !stuck && (wcnt >= wait_cycles);
    assign pslverr = pready && err_en;
    assign prdata  = (psel && penable && !pwrite) ? mem[paddr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (pready && pwrite && !pslverr) mem[paddr[5:2]] <= pwdata;
    end

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        int          wait_n;
        bit          err;
        bit          stuck;
        rsp_t        exp;
        int          lat;
    } vec_t;

    function automatic vec_t mkv(op_e op, logic [31:0] a, logic [31:0] d, logic [31:0] m,
                                 int w, bit e, bit s, logic [31:0] rd, bit sl, bit mm,
                                 bit to, int lat);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.mask = m;
        v.wait_n = w; v.err = e; v.stuck = s;
        v.exp.rdata = rd; v.exp.slverr = sl; v.exp.mismatch = mm; v.exp.timeout = to;
        v.lat = lat;
        return v;
    endfunction

    vec_t vecs [NV];
    rsp_t exp_q [$];
    rsp_t mon_exp;

    logic        tr_psel   [64];
    logic        tr_pen    [64];
    logic        tr_pwrite [64];
    logic [31:0] tr_pwdata [64];
    bit          any_pwrite;

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("rsp_rdata",    rsp_rdata,    mon_exp.rdata);
                check("rsp_slverr",   rsp_slverr,   mon_exp.slverr);
                check("rsp_mismatch", rsp_mismatch, mon_exp.mismatch);
                check("rsp_timeout",  rsp_timeout,  mon_exp.timeout);
            end
        end
    end

    // Cycle 0 is the accept cycle; lat is the cycle index where rsp_valid is first seen.
    task automatic issue(input vec_t v, output int lat);
        int guard;
        lat = -1;
        wait_cycles = v.wait_n;
        err_en = v.err;
        stuck = v.stuck;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = v.op;
        cmd_addr = v.addr;
        cmd_data = v.data;
        cmd_mask = v.mask;
        exp_q.push_back(v.exp);
        any_pwrite = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            tr_psel[c] = psel;
            tr_pen[c] = penable;
            tr_pwrite[c] = pwrite;
            tr_pwdata[c] = pwdata;
            any_pwrite |= pwrite;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("rsp_wait", rsp_valid, 1);
    endtask

    int lat;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mkv(OP_WRITE,  32'h0, 32'h0000_AAAA, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 3);
        vecs[1]  = mkv(OP_WRITE,  32'h0, 32'h0000_5555, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0, 3);
        vecs[2]  = mkv(OP_READ,   32'h0, 32'h0,         32'h0,         0, 0, 0, 32'h0000_5555, 0, 0, 0, 3);
        vecs[3]  = mkv(OP_VERIFY, 32'h0, 32'h0000_AAAA, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_5555, 0, 1, 0, 3);
        vecs[4]  = mkv(OP_VERIFY, 32'h0, 32'h0000_AAAA, 32'h0,         0, 0, 0, 32'h0000_5555, 0, 0, 0, 3);
        vecs[5]  = mkv(OP_RMW,    32'h0, 32'h0000_FFFF, 32'h0000_F0F0, 0, 0, 0, 32'h0000_5555, 0, 0, 0, 5);
        vecs[6]  = mkv(OP_READ,   32'h0, 32'h0,         32'h0,         3, 0, 0, 32'h0000_F5F5, 0, 0, 0, 6);
        vecs[7]  = mkv(OP_WRITE,  32'h8, 32'h1234_5678, 32'h0,         2, 0, 0, 32'h0,         0, 0, 0, 5);
        vecs[8]  = mkv(OP_READ,   32'h8, 32'h0,         32'h0,         3, 0, 0, 32'h1234_5678, 0, 0, 0, 6);
        vecs[9]  = mkv(OP_READ,   32'h0, 32'h0,         32'h0,         0, 0, 1, 32'h0,         0, 0, 1, 6);
        vecs[10] = mkv(OP_VERIFY, 32'h8, 32'h1234_0000, 32'hFFFF_0000, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 3);
        vecs[11] = mkv(OP_VERIFY, 32'h8, 32'h1234_0000, 32'h0000_FFFF, 0, 0, 0, 32'h1234_5678, 0, 1, 0, 3);
        vecs[12] = mkv(OP_RMW,    32'h8, 32'h0000_FFFF, 32'h0000_00FF, 0, 1, 0, 32'h1234_5678, 1, 0, 0, 3);
        vecs[13] = mkv(OP_READ,   32'h8, 32'h0,         32'h0,         0, 0, 0, 32'h1234_5678, 0, 0, 0, 3);
        vecs[14] = mkv(OP_WRITE,  32'h0, 32'h0000_DEAD, 32'h0,         0, 1, 0, 32'h0,         1, 0, 0, 3);
        vecs[15] = mkv(OP_RMW,    32'h8, 32'hFFFF_FFFF, 32'h0000_00FF, 1, 0, 0, 32'h1234_5678, 0, 0, 0, 7);
        vecs[16] = mkv(OP_READ,   32'h8, 32'h0,         32'h0,         0, 0, 0, 32'h1234_56FF, 0, 0, 0, 3);
        vecs[17] = mkv(OP_READ,   32'h0, 32'h0,         32'h0,         0, 0, 0, 32'h0000_F5F5, 0, 0, 0, 3);

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_addr = 32'h0;
        cmd_data = 32'h0;
        cmd_mask = 32'h0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel",      psel,      0);
        check("rst_penable",   penable,   0);
        check("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            case (i)
                0: begin
                    check("wr_psel_c1",   tr_psel[1],   1);
                    check("wr_pen_c1",    tr_pen[1],    0);
                    check("wr_pwrite_c1", tr_pwrite[1], 1);
                    check("wr_psel_c2",   tr_psel[2],   1);
                    check("wr_pen_c2",    tr_pen[2],    1);
                    check("wr_pwdata_c2", tr_pwdata[2], 32'h0000_AAAA);
                    check("wr_psel_c3",   tr_psel[3],   0);
                end
                5: begin
                    check("rmw_pwrite_c2", tr_pwrite[2], 0);
                    check("rmw_psel_c3",   tr_psel[3],   1);
                    check("rmw_pen_c3",    tr_pen[3],    0);
                    check("rmw_pwrite_c3", tr_pwrite[3], 1);
                    check("rmw_pwdata_c4", tr_pwdata[4], 32'h0000_F5F5);
                end
                9: begin
                    check("to_pen_c5",  tr_pen[5],  1);
                    check("to_psel_c6", tr_psel[6], 0);
                end
                12: check("slverr_no_write", any_pwrite, 0);
                default: ;
            endcase
        end

        // Response backpressure: fields and cmd_ready must hold while rsp_ready is low.
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(vecs[16], lat);
        check("bp_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1234_56FF);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_dropped", rsp_valid, 0);
        check("bp_cmd_ready_back", cmd_ready, 1);

        // Reset asserted in the middle of ACCESS.
        stuck = 1'b1;
        wait_cycles = 0;
        err_en = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = OP_READ;
        cmd_addr = 32'h8;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_penable", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_psel",      psel,      0);
        check("mid_rst_penable",   penable,   0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        @(negedge clk);
        check("mid_post_cmd_ready", cmd_ready, 1);
        check("mid_post_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("mid_post_rsp_quiet", rsp_valid, 0);

        issue(vecs[16], lat);
        check("post_rst_latency", lat, 3);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
